// File: rtl/mac_result_drain.sv
// Shadow-captures one MAC row's accumulators. Each word is requantized to a signed
// OUT_W value and streamed out one word per valid/ready transfer.
module mac_result_drain #(
  parameter int unsigned N_COLS  = 4,
  parameter int unsigned ACC_W   = 26,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5,
  localparam int unsigned IDX_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [N_COLS*ACC_W-1:0]   acc_in,
  input  logic [SHIFT_W-1:0]        shift,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      out_sat,
  output logic                      overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] Y_MIN = ~Y_MAX;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_COLS - 1);

  state_t state, state_d;
  logic signed [ACC_W-1:0] shadow [N_COLS];
  logic [SHIFT_W-1:0]      shift_q;
  logic                    load_shadow;
  logic [IDX_W-1:0]        sel_c;
  logic [OUT_W:0]          q_c;

  logic               busy_d, out_valid_d, out_last_d, out_sat_d, overrun_d;
  logic [OUT_W-1:0]   out_data_d;
  logic [IDX_W-1:0]   out_idx_d;

  // Round-half-up arithmetic shift, then saturate; returns {sat, data}.
  function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] x,
                                             input logic [SHIFT_W-1:0] sh);
    logic [SHIFT_W-1:0]      s;
    logic signed [ACC_W:0]   xe, rnd, y;
    s  = (sh > SHIFT_W'(ACC_W - 1)) ? SHIFT_W'(ACC_W - 1) : sh;
    xe = (ACC_W+1)'(x);
    if (s == '0) begin
      y = xe;
    end else begin
      rnd = (ACC_W+1)'(1) <<< (s - SHIFT_W'(1));
      y   = (xe + rnd) >>> s;
    end
    if (y > Y_MAX)      requant = {1'b1, Y_MAX[OUT_W-1:0]};
    else if (y < Y_MIN) requant = {1'b1, Y_MIN[OUT_W-1:0]};
    else                requant = {1'b0, y[OUT_W-1:0]};
  endfunction

  // LOAD fetches word 0; SEND prefetches the word after the one on the bus.
  assign sel_c = (state == SEND) ? out_idx + IDX_W'(1) : '0;
  assign q_c   = requant(shadow[sel_c], shift_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_idx   <= out_idx_d;
      out_last  <= out_last_d;
      out_sat   <= out_sat_d;
      overrun   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_idx_d   = out_idx;
    out_last_d  = out_last;
    out_sat_d   = out_sat;
    overrun_d   = overrun | (capture && (state != IDLE));
    load_shadow = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture) begin
          load_shadow = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        out_valid_d = 1'b1;
        out_idx_d   = sel_c;
        out_data_d  = q_c[OUT_W-1:0];
        out_sat_d   = q_c[OUT_W];
        out_last_d  = (sel_c == LAST_IDX);
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (out_idx == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            out_idx_d  = sel_c;
            out_data_d = q_c[OUT_W-1:0];
            out_sat_d  = q_c[OUT_W];
            out_last_d = (sel_c == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Shadow copy lets the MAC row keep accumulating during the drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      for (int k = 0; k < N_COLS; k++) shadow[k] <= '0;
    end else if (load_shadow) begin
      shift_q <= shift;
      for (int k = 0; k < N_COLS; k++) shadow[k] <= acc_in[k*ACC_W +: ACC_W];
    end
  end

endmodule
